// File: rtl/h80uart_rx.sv
// Registered first-word-fall-through FIFO: a push is visible on out_dat/out_vld the next cycle.
// Backpressure: a push while full and not popping is dropped and flagged on in_drop; push+pop when full both succeed.
module h80uart_rx_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          sysclk,
    input  logic          reset_n,
    input  logic          in_vld,
    input  logic [DW-1:0] in_dat,
    output logic          in_drop,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] remain;
    logic [DW-1:0] head_q, head_d;
    logic          empty, full, push, pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;

        empty   = (cnt_q == '0);
        full    = (cnt_q == CW'(DEPTH));
        pop     = out_rdy & ~empty;
        push    = in_vld & (~full | pop);
        in_drop = in_vld & full & ~pop;

        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Head register holds the last byte shown once the FIFO drains.
        remain = cnt_q - CW'(pop);
        if (cnt_d != '0) begin
            if (remain == '0) begin
                head_d = in_dat;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    assign out_vld = ~empty;
    assign out_dat = head_q;
endmodule

// 8N1 UART receiver: byte on rx_data/rx_valid one cycle after the stop-bit sample (FIFO empty).
// Backpressure: rx_ready drains the FIFO; a byte arriving while full is dropped and sets rx_overrun.
module h80uart_rx #(
    parameter int SYSCLK_FREQ = 27000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       uart_rxp,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    input  logic       err_clear
);
    localparam int CPB = SYSCLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW = $clog2(CPB);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          rxs;
    logic          push_vld;
    logic          ferr_set;
    logic          fifo_drop;

    always_comb begin
        sync1_d = uart_rxp;
        sync2_d = sync1_q;
    end
    assign rxs = sync2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push_vld = 1'b0;
        ferr_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = CW'(HALF - 1);
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                        cnt_d   = CW'(CPB - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shreg_d[idx_q] = rxs;
                    cnt_d          = CW'(CPB - 1);
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        push_vld = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_IDLE: begin
                // A held-low break parks here so it reports only one frame error.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_err_d = ferr_set | (frame_err_q & ~err_clear);
        overrun_d   = fifo_drop | (overrun_q & ~err_clear);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    h80uart_rx_fifo #(
        .DW    (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .in_vld  (push_vld),
        .in_dat  (shreg_q),
        .in_drop (fifo_drop),
        .out_vld (rx_valid),
        .out_rdy (rx_ready),
        .out_dat (rx_data)
    );

    assign rx_busy      = (state_q != IDLE) && (state_q != WAIT_IDLE);
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
endmodule

// File: tb/tb_h80uart_rx.sv
// Directed and randomised frames into h80uart_rx; a scoreboard queue checks every popped byte.
module tb_h80uart_rx;
    localparam int CLK_T = 100;
    localparam int BIT_T = 1600;

    logic       sysclk;
    logic       reset_n;
    logic       uart_rxp;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       err_clear;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    h80uart_rx #(
        .SYSCLK_FREQ (1600000),
        .BAUD        (100000),
        .FIFO_DEPTH  (4)
    ) dut (
        .sysclk       (sysclk),
        .reset_n      (reset_n),
        .uart_rxp     (uart_rxp),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .err_clear    (err_clear)
    );

    initial sysclk = 1'b0;
    always #(CLK_T / 2) sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid and ready are both high.
    always @(negedge sysclk) begin
        if (reset_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", rx_data);
            end else begin
                check("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_t);
        uart_rxp = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            uart_rxp = b[i];
            #(bit_t);
        end
        uart_rxp = stop_bit;
        #(bit_t);
        uart_rxp = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        cycles(1);
        err_clear = 1'b0;
    endtask

    initial begin
        #(9_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        logic [7:0] b;

        reset_n   = 1'b0;
        uart_rxp  = 1'b1;
        rx_ready  = 1'b1;
        err_clear = 1'b0;
        #(3 * CLK_T + 20);
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_ferr", 32'(rx_frame_err), 32'h0);
        check("rst_ovr", 32'(rx_overrun), 32'h0);
        @(posedge sysclk);
        #1 reset_n = 1'b1;
        cycles(5);

        // Single byte: first-valid latency and one-cycle valid with consumer ready.
        exp_q.push_back(8'hA5);
        n    = 0;
        seen = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, BIT_T);
            begin
                while (!seen && n < 400) begin
                    @(posedge sysclk);
                    n++;
                    #1;
                    if (rx_valid) seen = 1'b1;
                end
                check("a5_latency", 32'(n), 32'd155);
                cycles(1);
                check("a5_valid_1cyc", 32'(rx_valid), 32'h0);
            end
        join
        cycles(20);
        check("a5_ferr", 32'(rx_frame_err), 32'h0);
        check("a5_ovr", 32'(rx_overrun), 32'h0);

        // Start-bit glitch of 5 cycles.
        uart_rxp = 1'b0;
        cycles(5);
        uart_rxp = 1'b1;
        cycles(1);
        check("glitch_busy", 32'(rx_busy), 32'h1);
        cycles(30);
        check("glitch_idle", 32'(rx_busy), 32'h0);
        check("glitch_valid", 32'(rx_valid), 32'h0);
        check("glitch_ferr", 32'(rx_frame_err), 32'h0);

        // Frame error; err_clear lands on the very cycle the bad stop bit is sampled.
        @(posedge sysclk);
        #1;
        fork
            send_frame(8'h3C, 1'b0, BIT_T);
            begin
                cycles(154);
                err_clear = 1'b1;
                cycles(1);
                err_clear = 1'b0;
                check("ferr_set_wins", 32'(rx_frame_err), 32'h1);
            end
        join
        uart_rxp = 1'b0;
        cycles(10);
        pulse_clear();
        check("ferr_cleared", 32'(rx_frame_err), 32'h0);
        cycles(90);
        uart_rxp = 1'b1;
        cycles(200);
        check("break_single_err", 32'(rx_frame_err), 32'h0);
        check("ferr_no_valid", 32'(rx_valid), 32'h0);
        check("ferr_busy", 32'(rx_busy), 32'h0);

        // Overrun: five back-to-back bytes with no consumer.
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, BIT_T);
        cycles(20);
        check("ovr_set", 32'(rx_overrun), 32'h1);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        cycles(10);
        check("ovr_drained", 32'(rx_valid), 32'h0);
        check("ovr_queue", 32'(exp_q.size()), 32'd0);
        pulse_clear();
        check("ovr_cleared", 32'(rx_overrun), 32'h0);

        // Full FIFO: pop on exactly the push cycle of 0x77.
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send_frame(8'h11, 1'b1, BIT_T);
        send_frame(8'h22, 1'b1, BIT_T);
        send_frame(8'h33, 1'b1, BIT_T);
        send_frame(8'h44, 1'b1, BIT_T);
        @(posedge sysclk);
        #1;
        exp_q.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1, BIT_T);
            begin
                cycles(154);
                rx_ready = 1'b1;
                cycles(1);
                rx_ready = 1'b0;
            end
        join
        cycles(5);
        check("simul_no_ovr", 32'(rx_overrun), 32'h0);
        check("simul_valid", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        cycles(10);
        check("simul_queue", 32'(exp_q.size()), 32'd0);
        check("simul_last", 32'(rx_data), 32'h77);

        // Reset during data bit 4 of 0xFF.
        rx_ready = 1'b0;
        fork
            send_frame(8'hFF, 1'b1, BIT_T);
            begin
                #(5 * BIT_T + BIT_T / 2);
                reset_n = 1'b0;
                #(300);
                check("mid_rst_data", 32'(rx_data), 32'h0);
                check("mid_rst_valid", 32'(rx_valid), 32'h0);
                check("mid_rst_busy", 32'(rx_busy), 32'h0);
                check("mid_rst_ferr", 32'(rx_frame_err), 32'h0);
                check("mid_rst_ovr", 32'(rx_overrun), 32'h0);
            end
        join
        @(posedge sysclk);
        #1 reset_n = 1'b1;
        rx_ready = 1'b1;
        cycles(5);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, BIT_T);
        cycles(20);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        // Random bytes at +/-2% baud error.
        for (int k = 0; k < 200; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, (k % 2 == 1) ? 1632 : 1568);
            #($urandom_range(0, 3) * CLK_T);
        end
        cycles(300);
        check("rand_queue", 32'(exp_q.size()), 32'd0);
        check("rand_ferr", 32'(rx_frame_err), 32'h0);
        check("rand_ovr", 32'(rx_overrun), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
